// File: rtl/mem_access.sv
// MEM stage: passes ALU results to MEM/WB and runs data-memory accesses with
// a request/ack handshake, freezing earlier stages until the access completes.
module mem_access #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  WB_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_o,
    output logic [4:0]  rd_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       tmo_q, tmo_d;
    logic       mem_op, aligned, timeout_hit;

    assign mem_op      = |M_i;
    assign aligned     = (addr_i[1:0] == 2'b00);
    assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && aligned) begin
                    stall_o = 1'b1;
                    state_d = REQ;
                    wait_d  = 8'd0;
                    tmo_d   = 1'b0;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                // An ack on the last allowed cycle still wins over the timeout
                if (mem_ack_i) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Keep the freeze request quiet while the block is held in reset
        if (!rst_i) stall_o = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            tmo_q       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            WB_o        <= 2'b00;
            rdata_o     <= 32'd0;
            alu_o       <= 32'd0;
            rd_o        <= 5'd0;
            err_o       <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
            mem_req_o <= (state_d == REQ);
            case (state_q)
                IDLE: begin
                    alu_o <= addr_i;
                    rd_o  <= rd_i;
                    if (mem_op) begin
                        WB_o <= 2'b00;
                        if (aligned) begin
                            mem_addr_o  <= addr_i;
                            mem_wdata_o <= data_i;
                            mem_we_o    <= M_i[0];
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else begin
                        WB_o <= WB_i;
                    end
                end
                REQ: begin
                    WB_o <= 2'b00;
                    if (mem_ack_i && !mem_we_o) rdata_o <= mem_rdata_i;
                    if (!mem_ack_i && timeout_hit) err_o <= 1'b1;
                end
                DONE: begin
                    WB_o  <= tmo_q ? 2'b00 : WB_i;
                    alu_o <= addr_i;
                    rd_o  <= rd_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: each op pushes its expected MEM/WB result,
// which is popped and compared at the commit cycle.
module tb_mem_access;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i, M_i;
    logic [31:0] addr_i, data_i;
    logic [4:0]  rd_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  WB_o;
    logic [31:0] rdata_o, alu_o;
    logic [4:0]  rd_o;
    logic        err_o;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i), .addr_i(addr_i),
        .data_i(data_i), .rd_i(rd_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .WB_o(WB_o),
        .rdata_o(rdata_o), .alu_o(alu_o), .rd_o(rd_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ctl", {stall_o, mem_req_o, mem_we_o, err_o, WB_o, rd_o}, 64'd0);
        chk("rst_mem", {mem_addr_o, mem_wdata_o}, 64'd0);
        chk("rst_wb",  {alu_o, rdata_o}, 64'd0);
    endtask

    // Drives one EX/MEM op at a negedge and runs it to its commit cycle.
    // ack_n = REQ cycle on which to ack (0 = never); stray = ack outside REQ.
    task automatic do_op(input logic [1:0] wb, input logic [1:0] m,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input int ack_n,
                         input logic [31:0] rdat, input bit stray);
        exp_t e;
        bit   mis, is_mem, tmo, done;
        int   stalls, reqn, cyc;
        mis    = (m != 2'b00) && (addr[1:0] != 2'b00);
        is_mem = (m != 2'b00) && !mis;
        tmo    = is_mem && (ack_n == 0 || ack_n > TMO);
        if (is_mem && !tmo && !m[0]) m_rdata = rdat;
        if (mis || tmo) m_err = 1'b1;
        e.wb     = (mis || tmo || is_mem && 1'b0) ? 2'b00 : wb;
        e.alu    = addr;
        e.rd     = rd;
        e.rdata  = m_rdata;
        e.err    = m_err;
        e.reqs   = is_mem ? (tmo ? TMO : ack_n) : 0;
        e.stalls = is_mem ? 1 + e.reqs : 0;
        sb.push_back(e);

        WB_i = wb; M_i = m; addr_i = addr; data_i = data; rd_i = rd;
        stalls = 0; reqn = 0; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (mem_req_o) begin
                reqn++;
                if (reqn == 1) begin
                    chk("req_wb_bubble", WB_o, 2'b00);
                    chk("req_addr", mem_addr_o, addr);
                    chk("req_we", mem_we_o, m[0]);
                    if (m[0]) chk("req_wdata", mem_wdata_o, data);
                end else begin
                    chk("req_addr_stable", mem_addr_o, addr);
                end
                if (reqn == ack_n) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rdat;
                end
            end else if (stray) begin
                mem_ack_i = 1'b1;
            end
            #1;
            if (stall_o) stalls++;
            else done = 1;
            @(posedge clk_i);
            @(negedge clk_i);
            cyc++;
        end
        mem_ack_i = 1'b0;
        chk("op_done", done, 1);

        e = sb.pop_front();
        chk("wb_o",   WB_o,    e.wb);
        chk("alu_o",  alu_o,   e.alu);
        chk("rd_o",   rd_o,    e.rd);
        chk("rdata_o", rdata_o, e.rdata);
        chk("err_o",  err_o,   e.err);
        chk("stalls", stalls,  e.stalls);
        chk("req_cycles", reqn, e.reqs);
    endtask

    initial begin
        int rn;
        rst_i = 1'b0; WB_i = 0; M_i = 0; addr_i = 0; data_i = 0; rd_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        repeat (3) @(negedge clk_i);
        chk_reset_state();
        rst_i = 1'b1;

        do_op(2'b10, 2'b00, 32'h10,  32'h0,  5'd5, 0, 32'h0, 0);
        do_op(2'b11, 2'b10, 32'h100, 32'h0,  5'd7, 3, 32'hDEADBEEF, 0);
        do_op(2'b00, 2'b01, 32'h20,  32'h55, 5'd0, 1, 32'h0, 0);
        do_op(2'b10, 2'b00, 32'h44,  32'h0,  5'd9, 0, 32'h0, 1);
        do_op(2'b00, 2'b11, 32'h40,  32'hA5A5, 5'd3, 2, 32'h12345678, 0);
        do_op(2'b11, 2'b10, 32'h80,  32'h0,  5'd4, TMO, 32'hCAFEF00D, 0);
        for (int i = 0; i < 4; i++)
            do_op(2'($urandom), 2'b00, $urandom, $urandom, 5'($urandom), 0, 32'h0, 0);
        do_op(2'b11, 2'b10, 32'h200, 32'h0, 5'd6, 0, 32'h0, 0);

        // Reset asserted in the middle of a load's REQ phase
        WB_i = 2'b11; M_i = 2'b10; addr_i = 32'h300; rd_i = 5'd8;
        rn = 0;
        for (int c = 0; c < 20 && rn < 2; c++) begin
            @(negedge clk_i);
            if (mem_req_o) rn++;
        end
        chk("rst_reached_req", rn, 2);
        #1 rst_i = 1'b0;
        #1 chk_reset_state();
        m_rdata = 32'd0;
        m_err   = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_reset_state();
        rst_i = 1'b1;

        do_op(2'b11, 2'b10, 32'h300, 32'h0, 5'd8, 2, 32'h0BADF00D, 0);
        do_op(2'b11, 2'b10, 32'h102, 32'h0, 5'd2, 1, 32'h0, 0);
        M_i = 2'b00;
        @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
